// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: DATA_W-bit MSB-first transfers with a programmable SCLK
// half-period, CPOL/CPHA mode select and NUM_CS active-low chip selects.
module spi_master_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned NUM_CS  = 1,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic                                           in_clock,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [DATA_W-1:0]                              tx_data,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
  input  logic                                           miso,
  output logic                                           out_clock,
  output logic                                           mosi,
  output logic [NUM_CS-1:0]                              ncs,
  output logic                                           busy,
  output logic                                           done,
  output logic [DATA_W-1:0]                              rx_data
);

  localparam int unsigned CsW  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_W);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic                trail_q, trail_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [CsW-1:0]      cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                div_end;
  logic                active;
  logic [NUM_CS-1:0]   ncs_n;

  always_ff @(posedge in_clock) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      trail_q   <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      cs_q      <= '0;
      sclk_q    <= CPOL;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      trail_q   <= trail_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign div_end = (div_q == DivLast);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    trail_d   = trail_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;

    unique case (state_q)
      StIdle: begin
        sclk_d  = CPOL;
        div_d   = '0;
        bit_d   = '0;
        trail_d = 1'b0;
        if (start) begin
          state_d = StSetup;
          tx_sr_d = tx_data;
          rx_sr_d = '0;
          cs_d    = (32'(cs_sel) < NUM_CS) ? cs_sel : '0;
          // Mode 0/2 slaves sample on the first edge, so the MSB must be out during SETUP
          if (!CPHA) mosi_d = tx_data[DATA_W-1];
        end
      end

      StSetup: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) state_d = StXfer;
      end

      StXfer: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          sclk_d  = ~sclk_q;
          trail_d = ~trail_q;
          if (!trail_q) begin
            if (CPHA) begin
              mosi_d  = tx_sr_q[DATA_W-1];
              tx_sr_d = tx_sr_q << 1;
            end else begin
              rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
            end
          end else begin
            if (CPHA) begin
              rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
            end else if (bit_q != BitLast) begin
              mosi_d  = tx_sr_q[DATA_W-2];
              tx_sr_d = tx_sr_q << 1;
            end
            if (bit_q == BitLast) state_d = StHold;
            else                  bit_d   = bit_q + 1'b1;
          end
        end
      end

      StHold: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign active = (state_q != StIdle);

  always_comb begin
    ncs_n = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      ncs_n[i] = ~(active && (32'(cs_q) == i));
    end
  end

  assign out_clock = sclk_q;
  assign mosi      = mosi_q;
  assign ncs       = ncs_n;
  assign busy      = active;
  assign done      = done_q;
  assign rx_data   = rx_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: five instances cover modes 0-3, multi-CS and a
// 16-bit H=1 build; a scoreboard queue holds expected results popped on each done pulse.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  start = '0;
  logic [15:0] tx_data = '0;
  logic [1:0]  cs_sel = '0;
  logic [4:0]  loopback = 5'b10001;
  logic [15:0] slv_word = 16'h00C3;

  logic [4:0]       sclk, mosi, busy, done;
  logic [4:0][3:0]  ncs_a;
  logic [4:0][15:0] rx_a;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          inst;
    logic [15:0] rx;
    logic [15:0] sent;
    logic [3:0]  ncs;
    int          busy_len;
  } sb_t;

  sb_t sb[$];

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int unsigned DW  = (g == 4) ? 16 : 8;
    localparam int unsigned H   = (g == 4) ? 1 : 2;
    localparam int unsigned NCS = (g == 4) ? 3 : 4;
    localparam bit          POL = (g == 2 || g == 3);
    localparam bit          PHA = (g == 1 || g == 3);

    logic [DW-1:0]  rx_w;
    logic [NCS-1:0] ncs_w;
    logic           miso_w;
    logic           slv_miso = 1'b0;

    assign miso_w   = loopback[g] ? mosi[g] : slv_miso;
    assign rx_a[g]  = 16'(rx_w);
    assign ncs_a[g] = 4'(ncs_w);

    spi_master_param #(
      .DATA_W (DW),
      .CLK_DIV(H),
      .NUM_CS (NCS),
      .CPOL   (POL),
      .CPHA   (PHA)
    ) u_dut (
      .in_clock (clk),
      .reset    (rst),
      .start    (start[g]),
      .tx_data  (tx_data[DW-1:0]),
      .cs_sel   (cs_sel),
      .miso     (miso_w),
      .out_clock(sclk[g]),
      .mosi     (mosi[g]),
      .ncs      (ncs_w),
      .busy     (busy[g]),
      .done     (done[g]),
      .rx_data  (rx_w)
    );

    // Bus monitor plus mode-matched slave; decisions use values seen at the previous negedge
    logic           sclk_p = POL;
    logic           mosi_p = 1'b0;
    logic [NCS-1:0] ncs_p = '1;
    logic [DW-1:0]  s_sr = '0;
    logic [DW-1:0]  s_rx = '0;
    logic [3:0]     ncs_seen = '0;
    logic           lead;
    int             busy_n = 0;
    int             rise_n = 0;
    int             stab_err = 0;
    sb_t            e;

    always @(negedge clk) begin
      if (rst) begin
        busy_n   = 0;
        rise_n   = 0;
        stab_err = 0;
        slv_miso = 1'b0;
      end else begin
        if (busy[g]) begin
          busy_n++;
          if (busy_n == 1) ncs_seen = ncs_a[g];
        end
        if (ncs_w != '1 && ncs_p == '1) begin
          s_rx = '0;
          if (PHA) begin
            s_sr = slv_word[DW-1:0];
          end else begin
            slv_miso = slv_word[DW-1];
            s_sr     = slv_word[DW-1:0] << 1;
          end
        end
        if (sclk[g] != sclk_p) begin
          lead = (sclk[g] != POL);
          if (sclk[g] && !sclk_p) rise_n++;
          if (lead != PHA) begin
            if (mosi[g] != mosi_p) stab_err++;
            s_rx = {s_rx[DW-2:0], mosi[g]};
          end else begin
            slv_miso = s_sr[DW-1];
            s_sr     = s_sr << 1;
          end
        end
        if (done[g]) begin
          check_eq($sformatf("u%0d_done_expected", g), 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq($sformatf("u%0d_inst", g), 32'(g), 32'(e.inst));
            check_eq($sformatf("u%0d_rx_data", g), 32'(rx_a[g]), 32'(e.rx));
            check_eq($sformatf("u%0d_slave_rx", g), 32'(s_rx), 32'(e.sent));
            check_eq($sformatf("u%0d_ncs_active", g), 32'(ncs_seen), 32'(e.ncs));
            check_eq($sformatf("u%0d_busy_cycles", g), 32'(busy_n), 32'(e.busy_len));
            check_eq($sformatf("u%0d_sclk_rises", g), 32'(rise_n), 32'(DW));
            check_eq($sformatf("u%0d_sclk_idle", g), 32'(sclk[g]), 32'(POL));
            check_eq($sformatf("u%0d_mosi_stable", g), 32'(stab_err), 32'd0);
          end
          busy_n   = 0;
          rise_n   = 0;
          stab_err = 0;
        end
      end
      sclk_p = sclk[g];
      mosi_p = mosi[g];
      ncs_p  = ncs_w;
    end
  end

  task automatic push_exp(input int g, input logic [15:0] d, input logic [3:0] ncs_exp,
                          input int blen, input logic [15:0] rx_exp);
    sb_t x;
    x.inst     = g;
    x.rx       = rx_exp;
    x.sent     = d;
    x.ncs      = ncs_exp;
    x.busy_len = blen;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic xfer(input int g, input logic [15:0] d, input logic [1:0] cs,
                      input logic [3:0] ncs_exp, input int blen, input logic [15:0] rx_exp);
    push_exp(g, d, ncs_exp, blen, rx_exp);
    tx_data  = d;
    cs_sel   = cs;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    wait_drain(200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    logic prev;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      check_eq($sformatf("rst_ncs_%0d", g), 32'(ncs_a[g]), (g == 4) ? 32'h7 : 32'hF);
      check_eq($sformatf("rst_sclk_%0d", g), 32'(sclk[g]), 32'(g == 2 || g == 3));
      check_eq($sformatf("rst_busy_%0d", g), 32'(busy[g]), 32'd0);
      check_eq($sformatf("rst_rx_%0d", g), 32'(rx_a[g]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Mode 0 loopback
    xfer(0, 16'h00A5, 2'd0, 4'b1110, 36, 16'h00A5);

    // Modes 1..3 against a slave returning 0xC3
    for (int g = 1; g < 4; g++) xfer(g, 16'h003C, 2'd1, 4'b1101, 36, 16'h00C3);

    // Back-to-back with start held high
    push_exp(0, 16'h005A, 4'b1011, 36, 16'h005A);
    push_exp(0, 16'h0096, 4'b0111, 36, 16'h0096);
    tx_data  = 16'h005A;
    cs_sel   = 2'd2;
    start[0] = 1'b1;
    @(negedge clk);
    tx_data = 16'h0096;
    cs_sel  = 2'd3;
    for (int i = 0; i < 100 && !done[0]; i++) @(negedge clk);
    check_eq("b2b_done_seen", 32'(done[0]), 32'd1);
    check_eq("b2b_gap_ncs", 32'(ncs_a[0]), 32'hF);
    @(negedge clk);
    check_eq("b2b_second_ncs", 32'(ncs_a[0]), 32'b0111);
    start[0] = 1'b0;
    wait_drain(200);

    // Abort by reset after the third SCLK edge
    tx_data  = 16'h00F0;
    cs_sel   = 2'd2;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    edges = 0;
    prev  = sclk[0];
    for (int i = 0; i < 100 && edges < 3; i++) begin
      @(negedge clk);
      if (sclk[0] != prev) edges++;
      prev = sclk[0];
    end
    check_eq("abort_edges", 32'(edges), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ncs", 32'(ncs_a[0]), 32'hF);
    check_eq("abort_sclk", 32'(sclk[0]), 32'd0);
    check_eq("abort_busy", 32'(busy[0]), 32'd0);
    check_eq("abort_done", 32'(done[0]), 32'd0);
    check_eq("abort_mosi", 32'(mosi[0]), 32'd0);
    check_eq("abort_rx", 32'(rx_a[0]), 32'd0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    xfer(0, 16'h0069, 2'd1, 4'b1101, 36, 16'h0069);

    // start and tx_data changes while busy are ignored
    push_exp(0, 16'h0033, 4'b1110, 36, 16'h0033);
    tx_data  = 16'h0033;
    cs_sel   = 2'd0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    tx_data  = 16'h00FF;
    cs_sel   = 2'd3;
    start[0] = 1'b1;
    repeat (2) @(negedge clk);
    start[0] = 1'b0;
    wait_drain(200);
    repeat (20) @(negedge clk);

    // 16-bit, H=1, out-of-range cs_sel falls back to CS 0
    xfer(4, 16'h8001, 2'd3, 4'b0110, 34, 16'h8001);

    repeat (10) @(negedge clk);
    check_eq("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
